pipeline_stall_ctrl: RTL and testbench

//  Consumer side of the load-use stall request. Turns stall/redirect/memory-wait

---
 rtl/pipeline_stall_ctrl_if.sv | 50 +++++
 rtl/pipeline_stall_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Stall-control bundle: hazard/redirect/memory-wait events in, stage controls out.
// Latency: none, wires only.
// Backpressure: none; mem_busy and hazard_stall are the hold requests carried here.
interface pipeline_stall_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    // events from the pipeline
    logic             hazard_stall;
    logic             ex_branch_taken;
    logic [XLEN-1:0]  ex_branch_target;
    logic             mem_busy;

    // stage controls back to the pipeline
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;

    // status / debug
    logic             mem_timeout_err;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;

    // pipeline side: raises events, consumes controls
    modport master (
        output hazard_stall, ex_branch_taken, ex_branch_target, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush,
               redirect_valid, redirect_pc, mem_timeout_err, ctrl_state,
               stall_cnt, flush_cnt, memwait_cnt
    );

    // controller side
    modport slave (
        input  hazard_stall, ex_branch_taken, ex_branch_target, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush,
               redirect_valid, redirect_pc, mem_timeout_err, ctrl_state,
               stall_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller with held branch redirect and memory-wait watchdog.
// Latency: controls are combinational from inputs and registered state (zero cycles).
// Backpressure: mem_busy freezes PC..EX/MEM and bubbles WB; load-use stall freezes PC/IF-ID.
// Optional perf counters enabled by defining HAZARD_PERF_EN; otherwise counters read 0.
module pipeline_stall_ctrl #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_TIMEOUT  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             pend_q;
    logic [XLEN-1:0]  pend_pc_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             err_q;

    logic             hold;
    logic             do_redirect;
    logic             do_stall;
    logic             wd_hit;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] memwait_cnt_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus per-cycle priority resolution of stage controls
    always_comb begin
        state_d        = state_q;
        hold           = 1'b0;
        do_redirect    = 1'b0;
        do_stall       = 1'b0;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        id_ex_en       = 1'b0;
        ex_mem_en      = 1'b0;
        mem_wb_en      = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        mem_wb_flush   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = pend_pc_q;
        // the busy cycle that completes MEM_TIMEOUT consecutive waits
        wd_hit         = bus.mem_busy && (wd_cnt_q == WD_LAST);

        case (state_q)
            S_RUN: begin
                if (bus.mem_busy) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (!bus.mem_busy)                        state_d = S_RUN;
                else if (wd_hit || (wd_cnt_q == WD_MAX))  state_d = S_TIMEOUT;
            end
            S_TIMEOUT: begin
                if (!bus.mem_busy) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        // all controls are forced quiet while reset is asserted
        if (rst_n) begin
            if (bus.mem_busy || (state_q == S_TIMEOUT)) begin
                // memory hold: freeze everything upstream, push a bubble into WB
                hold         = 1'b1;
                mem_wb_en    = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (bus.ex_branch_taken || pend_q) begin
                // a redirect held across a memory wait is older than any live pulse
                do_redirect    = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = pend_q ? pend_pc_q : bus.ex_branch_target;
                pc_en          = 1'b1;
                if_id_en       = 1'b1;
                id_ex_en       = 1'b1;
                ex_mem_en      = 1'b1;
                mem_wb_en      = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
            end else if (bus.hazard_stall) begin
                // load-use: hold fetch/decode, bubble into EX
                do_stall    = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    // Pending redirect: capture branch pulses during a hold, release once it fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else if (hold && bus.ex_branch_taken) begin
            pend_q    <= 1'b1;
            pend_pc_q <= bus.ex_branch_target;
        end else if (do_redirect) begin
            pend_q    <= 1'b0;
        end
    end

    // Watchdog: count consecutive busy cycles, latch a sticky error on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!bus.mem_busy)          wd_cnt_q <= '0;
            else if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_hit) err_q <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating perf counters for stalls, redirects and memory-wait cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (do_stall && (stall_cnt_q != '1))         stall_cnt_q   <= stall_cnt_q + 1'b1;
            if (redirect_valid && (flush_cnt_q != '1))   flush_cnt_q   <= flush_cnt_q + 1'b1;
            if (bus.mem_busy && (memwait_cnt_q != '1))   memwait_cnt_q <= memwait_cnt_q + 1'b1;
        end
    end
`else
    assign stall_cnt_q   = '0;
    assign flush_cnt_q   = '0;
    assign memwait_cnt_q = '0;
`endif

    assign bus.pc_en           = pc_en;
    assign bus.if_id_en        = if_id_en;
    assign bus.id_ex_en        = id_ex_en;
    assign bus.ex_mem_en       = ex_mem_en;
    assign bus.mem_wb_en       = mem_wb_en;
    assign bus.if_id_flush     = if_id_flush;
    assign bus.id_ex_flush     = id_ex_flush;
    assign bus.mem_wb_flush    = mem_wb_flush;
    assign bus.redirect_valid  = redirect_valid;
    assign bus.redirect_pc     = redirect_pc;
    // error is visible in the very busy cycle that expires the watchdog
    assign bus.mem_timeout_err = rst_n && (err_q || wd_hit);
    assign bus.ctrl_state      = state_q;
    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;
    assign bus.memwait_cnt     = memwait_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: vector table plus hand sequences, scoreboard queue.
// Latency: outputs are combinational, compared on the falling edge of the drive cycle.
// Backpressure: mem_busy sequences exercise hold, redirect deferral and watchdog.
module tb_pipeline_stall_ctrl;

    typedef struct {
        logic        hs;
        logic        bt;
        logic [31:0] tgt;
        logic        mb;
        logic [4:0]  en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [2:0]  fl;   // {if_id, id_ex, mem_wb}
        logic        rv;
        logic [31:0] rpc;
        logic        err;
        logic [1:0]  st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[21];
    vec_t exp_q[$];

    pipeline_stall_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

    pipeline_stall_ctrl #(.XLEN(32), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t v(input logic hs, input logic bt, input logic [31:0] tgt,
                               input logic mb, input logic [4:0] en, input logic [2:0] fl,
                               input logic rv, input logic [31:0] rpc, input logic err,
                               input logic [1:0] st);
        vec_t r;
        r.hs = hs; r.bt = bt; r.tgt = tgt; r.mb = mb;
        r.en = en; r.fl = fl; r.rv = rv; r.rpc = rpc; r.err = err; r.st = st;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        bus.hazard_stall     = x.hs;
        bus.ex_branch_taken  = x.bt;
        bus.ex_branch_target = x.tgt;
        bus.mem_busy         = x.mb;
    endtask

    // pop the oldest expectation and compare it with what the DUT shows now
    task automatic check_now(input string name);
        vec_t        e;
        logic [43:0] act;
        logic [43:0] req;
        e   = exp_q.pop_front();
        act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
               bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush,
               bus.redirect_valid, bus.redirect_pc, bus.mem_timeout_err, bus.ctrl_state};
        req = {e.en, e.fl, e.rv, e.rpc, e.err, e.st};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got en=%b fl=%b rv=%b rpc=%h err=%b st=%0d, want en=%b fl=%b rv=%b rpc=%h err=%b st=%0d",
                     name, act[43:39], act[38:36], act[35], act[34:3], act[2], act[1:0],
                     e.en, e.fl, e.rv, e.rpc, e.err, e.st);
        end
    endtask

    // one clock cycle: drive after the rising edge, compare on the falling edge
    task automatic step(input vec_t x, input string name);
        @(posedge clk);
        #1;
        drive(x);
        exp_q.push_back(x);
        @(negedge clk);
        check_now(name);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    initial begin
        vec_t idle0;
        int   exp_stall;
        int   exp_flush;
        int   exp_memwait;

        //              hs bt tgt         mb en        fl      rv rpc         err st
        vecs[0]  = v(0, 0, 32'h0,   0, 5'b11111, 3'b000, 0, 32'h0,   0, 2'd0);
        vecs[1]  = v(1, 0, 32'h0,   0, 5'b00111, 3'b010, 0, 32'h0,   0, 2'd0);
        vecs[2]  = v(0, 0, 32'h0,   0, 5'b11111, 3'b000, 0, 32'h0,   0, 2'd0);
        vecs[3]  = v(1, 1, 32'h100, 0, 5'b11111, 3'b110, 1, 32'h100, 0, 2'd0);
        vecs[4]  = v(0, 0, 32'h0,   0, 5'b11111, 3'b000, 0, 32'h0,   0, 2'd0);
        vecs[5]  = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h0,   0, 2'd0);
        vecs[6]  = v(0, 1, 32'h180, 1, 5'b00001, 3'b001, 0, 32'h0,   0, 2'd1);
        vecs[7]  = v(0, 1, 32'h200, 1, 5'b00001, 3'b001, 0, 32'h180, 0, 2'd1);
        vecs[8]  = v(0, 1, 32'h999, 0, 5'b11111, 3'b110, 1, 32'h200, 0, 2'd1);
        vecs[9]  = v(0, 0, 32'h0,   0, 5'b11111, 3'b000, 0, 32'h200, 0, 2'd0);
        vecs[10] = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 0, 2'd0);
        vecs[11] = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 0, 2'd1);
        vecs[12] = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 0, 2'd1);
        vecs[13] = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 1, 2'd1);
        vecs[14] = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 1, 2'd2);
        vecs[15] = v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 1, 2'd2);
        vecs[16] = v(0, 0, 32'h0,   0, 5'b00001, 3'b001, 0, 32'h200, 1, 2'd2);
        vecs[17] = v(0, 0, 32'h0,   0, 5'b11111, 3'b000, 0, 32'h200, 1, 2'd0);
        vecs[18] = v(1, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h200, 1, 2'd0);
        vecs[19] = v(1, 0, 32'h0,   0, 5'b00111, 3'b010, 0, 32'h200, 1, 2'd1);
        vecs[20] = v(0, 0, 32'h0,   0, 5'b11111, 3'b000, 0, 32'h200, 1, 2'd0);

        // reset asserted with every event input active: everything must stay quiet
        drive(v(1, 1, 32'h55, 1, 5'b0, 3'b0, 0, 32'h0, 0, 2'd0));
        repeat (2) @(negedge clk);
        exp_q.push_back(v(1, 1, 32'h55, 1, 5'b00000, 3'b000, 0, 32'h0, 0, 2'd0));
        check_now("reset_hold");
        idle0 = v(0, 0, 32'h0, 0, 5'b0, 3'b0, 0, 32'h0, 0, 2'd0);
        drive(idle0);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef HAZARD_PERF_EN
        exp_stall = 2; exp_flush = 2; exp_memwait = 10;
`else
        exp_stall = 0; exp_flush = 0; exp_memwait = 0;
`endif
        check_val("stall_cnt",   bus.stall_cnt,   32'(exp_stall));
        check_val("flush_cnt",   bus.flush_cnt,   32'(exp_flush));
        check_val("memwait_cnt", bus.memwait_cnt, 32'(exp_memwait));

        // branch captured during a wait, then reset lands before it can fire
        step(v(0, 1, 32'h300, 1, 5'b00001, 3'b001, 0, 32'h200, 1, 2'd0), "pend_capture");
        step(v(0, 0, 32'h0,   1, 5'b00001, 3'b001, 0, 32'h300, 1, 2'd1), "pend_held");
        drive(idle0);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(v(0, 0, 32'h0, 0, 5'b00000, 3'b000, 0, 32'h0, 0, 2'd0));
        check_now("reset_async");
        #2;
        rst_n = 1'b1;
        step(v(0, 0, 32'h0, 0, 5'b11111, 3'b000, 0, 32'h0, 0, 2'd0), "post_reset_idle");
        step(v(0, 0, 32'h0, 0, 5'b11111, 3'b000, 0, 32'h0, 0, 2'd0), "post_reset_idle2");
        check_val("stall_cnt_cleared",   bus.stall_cnt,   32'd0);
        check_val("flush_cnt_cleared",   bus.flush_cnt,   32'd0);
        check_val("memwait_cnt_cleared", bus.memwait_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
